// File: rtl/uart_pkt_parser.sv
// Byte-stream packet parser: finds SYNC/LEN/payload/CHK frames, verifies the XOR
// checksum, and releases the buffered payload downstream only after it passes.
module uart_pkt_parser #(
   parameter logic [7:0]  SYNC_BYTE = 8'hA5,
   parameter int unsigned MAX_LEN   = 16
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [7:0] i_data,
   input  logic       i_valid,
   output logic       o_ready,
   input  logic       i_rxerr,
   output logic [7:0] o_data,
   output logic       o_valid,
   input  logic       i_ready,
   output logic       o_last,
   output logic [7:0] o_len,
   output logic       o_err,
   output logic [1:0] o_errcode
);

   localparam int unsigned IW = $clog2(MAX_LEN + 1);
   localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   localparam logic [1:0] ERR_LEN   = 2'b01;
   localparam logic [1:0] ERR_CHK   = 2'b10;
   localparam logic [1:0] ERR_RX    = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN,
      S_PAYLOAD,
      S_CHK,
      S_EMIT
   } state_t;

   state_t          state_q, state_n;
   logic [7:0]      len_q, len_n;
   logic [7:0]      chk_q, chk_n;
   logic [IW-1:0]   wr_idx_q, wr_idx_n;
   logic [IW-1:0]   rd_idx_q, rd_idx_n;
   logic            ready_n;
   logic            valid_n;
   logic [7:0]      data_n;
   logic            last_n;
   logic [7:0]      olen_n;
   logic            err_n;
   logic [1:0]      code_n;
   logic            wr_en;
   logic            in_xfer;

   logic [7:0]      buf_mem [MAX_LEN];

   assign in_xfer = i_valid && o_ready;

   // State and registered outputs
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= S_IDLE;
         len_q     <= 8'd0;
         chk_q     <= 8'd0;
         wr_idx_q  <= '0;
         rd_idx_q  <= '0;
         o_ready   <= 1'b1;
         o_valid   <= 1'b0;
         o_data    <= 8'd0;
         o_last    <= 1'b0;
         o_len     <= 8'd0;
         o_err     <= 1'b0;
         o_errcode <= 2'b00;
      end else begin
         state_q   <= state_n;
         len_q     <= len_n;
         chk_q     <= chk_n;
         wr_idx_q  <= wr_idx_n;
         rd_idx_q  <= rd_idx_n;
         o_ready   <= ready_n;
         o_valid   <= valid_n;
         o_data    <= data_n;
         o_last    <= last_n;
         o_len     <= olen_n;
         o_err     <= err_n;
         o_errcode <= code_n;
      end
   end

   // Payload buffer; contents are don't-care until written
   always_ff @(posedge i_clk) begin
      if (wr_en) begin
         buf_mem[AW'(wr_idx_q)] <= i_data;
      end
   end

   // Next-state and output decode
   always_comb begin
      state_n  = state_q;
      len_n    = len_q;
      chk_n    = chk_q;
      wr_idx_n = wr_idx_q;
      rd_idx_n = rd_idx_q;
      valid_n  = o_valid;
      data_n   = o_data;
      last_n   = o_last;
      olen_n   = o_len;
      err_n    = 1'b0;
      code_n   = o_errcode;
      wr_en    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (in_xfer && (i_data == SYNC_BYTE)) begin
               state_n = S_LEN;
            end
         end

         S_LEN: begin
            if (i_rxerr) begin
               err_n   = 1'b1;
               code_n  = ERR_RX;
               state_n = S_IDLE;
            end else if (in_xfer) begin
               if ((i_data == 8'd0) || (32'(i_data) > MAX_LEN)) begin
                  err_n   = 1'b1;
                  code_n  = ERR_LEN;
                  state_n = S_IDLE;
               end else begin
                  len_n    = i_data;
                  chk_n    = i_data;
                  wr_idx_n = '0;
                  state_n  = S_PAYLOAD;
               end
            end
         end

         S_PAYLOAD: begin
            if (i_rxerr) begin
               err_n   = 1'b1;
               code_n  = ERR_RX;
               state_n = S_IDLE;
            end else if (in_xfer) begin
               wr_en    = 1'b1;
               chk_n    = chk_q ^ i_data;
               wr_idx_n = wr_idx_q + IW'(1);
               if ((8'(wr_idx_q) + 8'd1) == len_q) begin
                  state_n = S_CHK;
               end
            end
         end

         S_CHK: begin
            if (i_rxerr) begin
               err_n   = 1'b1;
               code_n  = ERR_RX;
               state_n = S_IDLE;
            end else if (in_xfer) begin
               if (i_data == chk_q) begin
                  state_n  = S_EMIT;
                  valid_n  = 1'b1;
                  data_n   = buf_mem[0];
                  last_n   = (len_q == 8'd1);
                  olen_n   = len_q;
                  rd_idx_n = '0;
               end else begin
                  err_n   = 1'b1;
                  code_n  = ERR_CHK;
                  state_n = S_IDLE;
               end
            end
         end

         S_EMIT: begin
            // Next byte is fetched on the transfer edge so there are no bubbles
            if (o_valid && i_ready) begin
               if (o_last) begin
                  valid_n = 1'b0;
                  last_n  = 1'b0;
                  state_n = S_IDLE;
               end else begin
                  rd_idx_n = rd_idx_q + IW'(1);
                  data_n   = buf_mem[AW'(rd_idx_q + IW'(1))];
                  last_n   = ((8'(rd_idx_q) + 8'd2) == len_q);
               end
            end
         end

         default: begin
            state_n = S_IDLE;
            valid_n = 1'b0;
            last_n  = 1'b0;
         end
      endcase

      ready_n = (state_n != S_EMIT);
   end

endmodule

// File: tb/tb_uart_pkt_parser.sv
// Directed bench for uart_pkt_parser: good frames, bad length/checksum, rx errors,
// downstream back-pressure and mid-frame resets, with hand-computed expectations.
module tb_uart_pkt_parser;

   logic       i_clk = 1'b0;
   logic       i_rst;
   logic [7:0] i_data;
   logic       i_valid;
   logic       o_ready;
   logic       i_rxerr;
   logic [7:0] o_data;
   logic       o_valid;
   logic       i_ready;
   logic       o_last;
   logic [7:0] o_len;
   logic       o_err;
   logic [1:0] o_errcode;

   always #5 i_clk = ~i_clk;

   uart_pkt_parser #(.SYNC_BYTE(8'hA5), .MAX_LEN(16)) dut (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_data    (i_data),
      .i_valid   (i_valid),
      .o_ready   (o_ready),
      .i_rxerr   (i_rxerr),
      .o_data    (o_data),
      .o_valid   (o_valid),
      .i_ready   (i_ready),
      .o_last    (o_last),
      .o_len     (o_len),
      .o_err     (o_err),
      .o_errcode (o_errcode)
   );

   int         n_checks = 0;
   int         n_errors = 0;

   logic [7:0] tx_q[$];
   logic [7:0] exp_q[$];
   logic [8:0] rx_q[$];
   int         err_cnt = 0;
   logic [1:0] last_code = 2'b00;
   logic [7:0] exp_len = 8'd0;
   int         ready_mode = 0;

   logic       prev_err = 1'b0;
   logic       prev_stall = 1'b0;
   logic [7:0] prev_data = 8'd0;
   logic       prev_last = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Observe the output side every cycle, away from the active edge
   always @(negedge i_clk) begin
      if (o_err) begin
         err_cnt++;
         last_code = o_errcode;
         check("err_twice", 32'(prev_err), 32'd0);
      end
      prev_err = o_err;
      if (o_valid) begin
         check("rdy_emit", 32'(o_ready), 32'd0);
         check("len_emit", 32'(o_len), 32'(exp_len));
         if (prev_stall) begin
            check("hold_data", 32'(o_data), 32'(prev_data));
            check("hold_last", 32'(o_last), 32'(prev_last));
         end
         if (i_ready) rx_q.push_back({o_last, o_data});
      end
      prev_stall = o_valid && !i_ready;
      prev_data  = o_data;
      prev_last  = o_last;
   end

   task automatic send_byte(input logic [7:0] b, input logic rx);
      i_valid = 1'b1;
      i_data  = b;
      i_rxerr = rx;
      @(posedge i_clk);
      #1;
      i_valid = 1'b0;
      i_rxerr = 1'b0;
   endtask

   task automatic send_tx(input int rx_at);
      foreach (tx_q[i]) send_byte(tx_q[i], (i == rx_at));
   endtask

   task automatic drain(output int n);
      n = 0;
      while (o_valid && n < 200) begin
         @(posedge i_clk);
         #1;
         n++;
         if (ready_mode == 1) i_ready = ~i_ready;
      end
      if (o_valid) check("drain_timeout", 32'(o_valid), 32'd0);
      i_ready = 1'b1;
   endtask

   task automatic idle_cycles(input int k);
      repeat (k) begin
         @(posedge i_clk);
         #1;
      end
   endtask

   task automatic expect_payload(input string tag);
      check({tag, "_nbytes"}, 32'(rx_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
         check({tag, "_data"}, 32'(rx_q[i][7:0]), 32'(exp_q[i]));
         check({tag, "_last"}, 32'(rx_q[i][8]), 32'(i == exp_q.size() - 1));
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_valid"}, 32'(o_valid), 32'd0);
      check({tag, "_last"}, 32'(o_last), 32'd0);
      check({tag, "_err"}, 32'(o_err), 32'd0);
      check({tag, "_code"}, 32'(o_errcode), 32'd0);
      check({tag, "_len"}, 32'(o_len), 32'd0);
      check({tag, "_data"}, 32'(o_data), 32'd0);
      check({tag, "_ready"}, 32'(o_ready), 32'd1);
   endtask

   task automatic clear_obs();
      rx_q.delete();
      err_cnt = 0;
   endtask

   initial begin
      int n;
      i_rst   = 1'b1;
      i_data  = 8'h00;
      i_valid = 1'b0;
      i_rxerr = 1'b0;
      i_ready = 1'b1;
      idle_cycles(3);
      check_reset_vals("rst");
      i_rst = 1'b0;
      idle_cycles(1);
      check("rst_rel_ready", 32'(o_ready), 32'd1);

      // Good 3-byte frame; checksum 03^11^22^33 = 03
      clear_obs();
      exp_len = 8'd3;
      tx_q  = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
      exp_q = '{8'h11, 8'h22, 8'h33};
      send_tx(-1);
      check("f1_lat_valid", 32'(o_valid), 32'd1);
      check("f1_first", 32'(o_data), 32'h11);
      check("f1_len", 32'(o_len), 32'd3);
      drain(n);
      check("f1_cycles", 32'(n), 32'd3);
      idle_cycles(1);
      expect_payload("f1");
      check("f1_errs", 32'(err_cnt), 32'd0);
      check("f1_idle_ready", 32'(o_ready), 32'd1);

      // Bad checksum (02^AA^BB = 13, sent 00), then a 1-byte frame
      clear_obs();
      tx_q = '{8'hA5, 8'h02, 8'hAA, 8'hBB, 8'h00};
      send_tx(-1);
      idle_cycles(2);
      check("f2_errs", 32'(err_cnt), 32'd1);
      check("f2_code", 32'(last_code), 32'b10);
      check("f2_code_held", 32'(o_errcode), 32'b10);
      check("f2_nbytes", 32'(rx_q.size()), 32'd0);
      clear_obs();
      exp_len = 8'd1;
      tx_q  = '{8'hA5, 8'h01, 8'h5A, 8'h5B};
      exp_q = '{8'h5A};
      send_tx(-1);
      check("f3_first", 32'(o_data), 32'h5A);
      check("f3_last", 32'(o_last), 32'd1);
      drain(n);
      idle_cycles(1);
      expect_payload("f3");
      check("f3_errs", 32'(err_cnt), 32'd0);

      // Length 0 and length 17 rejected, stray byte in IDLE silent
      clear_obs();
      tx_q = '{8'hA5, 8'h00};
      send_tx(-1);
      idle_cycles(2);
      check("len0_errs", 32'(err_cnt), 32'd1);
      check("len0_code", 32'(last_code), 32'b01);
      tx_q = '{8'hA5, 8'h11, 8'h5C};
      send_tx(-1);
      idle_cycles(2);
      check("len17_errs", 32'(err_cnt), 32'd2);
      check("len17_code", 32'(last_code), 32'b01);
      check("len_nbytes", 32'(rx_q.size()), 32'd0);

      // LEN equal to the sync value is just a length (too big here)
      clear_obs();
      tx_q = '{8'hA5, 8'hA5};
      send_tx(-1);
      idle_cycles(2);
      check("lensync_code", 32'(last_code), 32'b01);
      check("lensync_errs", 32'(err_cnt), 32'd1);

      // rx error on second payload byte; trailing byte lands in IDLE
      clear_obs();
      tx_q = '{8'hA5, 8'h04, 8'h10, 8'h20, 8'h30};
      send_tx(3);
      idle_cycles(2);
      check("rx_errs", 32'(err_cnt), 32'd1);
      check("rx_code", 32'(last_code), 32'b11);
      clear_obs();
      exp_len = 8'd2;
      tx_q  = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h01};
      exp_q = '{8'h01, 8'h02};
      send_tx(-1);
      drain(n);
      idle_cycles(1);
      expect_payload("resync");
      check("resync_errs", 32'(err_cnt), 32'd0);
      check("resync_code_held", 32'(o_errcode), 32'b11);

      // Back-pressure: i_ready toggles; checksum 04^DE^AD^BE^EF = 26
      clear_obs();
      exp_len = 8'd4;
      ready_mode = 1;
      i_ready = 1'b0;
      tx_q  = '{8'hA5, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h26};
      exp_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      send_tx(-1);
      drain(n);
      ready_mode = 0;
      check("bp_cycles", 32'(n), 32'd8);
      idle_cycles(1);
      expect_payload("bp");

      // Reset mid-payload, then a clean frame (01^77 = 76)
      clear_obs();
      tx_q = '{8'hA5, 8'h03, 8'h11};
      send_tx(-1);
      i_rst = 1'b1;
      idle_cycles(1);
      check_reset_vals("rstp");
      i_rst = 1'b0;
      exp_len = 8'd1;
      tx_q  = '{8'hA5, 8'h01, 8'h77, 8'h76};
      exp_q = '{8'h77};
      send_tx(-1);
      drain(n);
      idle_cycles(1);
      expect_payload("rstp");
      check("rstp_errs", 32'(err_cnt), 32'd0);

      // Reset mid-EMIT while stalled: packet abandoned silently
      clear_obs();
      exp_len = 8'd3;
      i_ready = 1'b0;
      tx_q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
      send_tx(-1);
      idle_cycles(2);
      check("rste_valid_pre", 32'(o_valid), 32'd1);
      i_rst = 1'b1;
      idle_cycles(1);
      check_reset_vals("rste");
      i_rst = 1'b0;
      i_ready = 1'b1;
      idle_cycles(3);
      check("rste_nbytes", 32'(rx_q.size()), 32'd0);
      check("rste_errs", 32'(err_cnt), 32'd0);
      clear_obs();
      exp_len = 8'd2;
      tx_q  = '{8'hA5, 8'h02, 8'hC3, 8'h3C, 8'hFD};
      exp_q = '{8'hC3, 8'h3C};
      send_tx(-1);
      drain(n);
      idle_cycles(1);
      expect_payload("rste_clean");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
